// File: rtl/vga_pkg.sv
// vga_pkg: screen geometry, pixel field widths, arbiter state enum and round-robin distance helper
package vga_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int C_W = 3;
  typedef enum logic {IDLE, OWNED} state_t;
  function automatic int rr_dist(int i, int last, int n);
    return (i - last - 1 + n) % n;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: round-robin pick (req, last -> one-hot pick, valid) favouring the requester just after last
module rr_pick import vga_pkg::*; #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  pick,
  output logic          valid
);
  int best;
  always_comb begin
    best = N;
    pick = '0;
    for (int i = 0; i < N; i++)
      if (req[i] && rr_dist(i, int'(last), N) < best) best = rr_dist(i, int'(last), N);
    valid = best < N;
    for (int i = 0; i < N; i++) pick[i] = req[i] && rr_dist(i, int'(last), N) == best;
  end
endmodule

// File: rtl/plot_arbiter.sv
// plot_arbiter: grants one drawing requester (req/gnt) the VGA port, forwards its pixels (pix_*) to vga_* with clipping and a drop_count
module plot_arbiter import vga_pkg::*; #(
  parameter int NUM_REQ = 3,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  output logic [NUM_REQ-1:0]     gnt,
  input  logic [NUM_REQ-1:0]     pix_valid,
  input  logic [NUM_REQ*X_W-1:0] pix_x,
  input  logic [NUM_REQ*Y_W-1:0] pix_y,
  input  logic [NUM_REQ*C_W-1:0] pix_colour,
  output logic [NUM_REQ-1:0]     pix_ready,
  output logic [X_W-1:0]         vga_x,
  output logic [Y_W-1:0]         vga_y,
  output logic [C_W-1:0]         vga_colour,
  output logic                   vga_plot,
  output logic                   busy,
  output logic [CNT_W-1:0]       drop_count
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  state_t state_q, state_d;
  logic [IW-1:0] owner_q, owner_d, last_q, last_d, pick_idx;
  logic [NUM_REQ-1:0] pick;
  logic pick_vld, accept, in_bounds;
  logic [X_W-1:0] cur_x, vga_x_q, vga_x_d;
  logic [Y_W-1:0] cur_y, vga_y_q, vga_y_d;
  logic [C_W-1:0] cur_c, vga_c_q, vga_c_d;
  logic vga_plot_q, vga_plot_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req   (req),
    .last  (last_q),
    .pick  (pick),
    .valid (pick_vld)
  );
  always_comb begin
    pick_idx = '0;
    gnt = '0;
    cur_x = '0;
    cur_y = '0;
    cur_c = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) pick_idx = IW'(i);
      gnt[i] = state_q == OWNED && owner_q == IW'(i);
      if (owner_q == IW'(i)) begin
        cur_x = pix_x[i*X_W +: X_W];
        cur_y = pix_y[i*Y_W +: Y_W];
        cur_c = pix_colour[i*C_W +: C_W];
      end
    end
    pix_ready = gnt & req;
    accept = |(pix_ready & pix_valid);
    in_bounds = cur_x < X_W'(SCREEN_W) && cur_y < Y_W'(SCREEN_H);
    state_d = state_q == IDLE ? (pick_vld ? OWNED : IDLE) : (|pix_ready ? OWNED : IDLE);
    owner_d = state_q == IDLE && pick_vld ? pick_idx : owner_q;
    last_d = state_q == OWNED && !(|pix_ready) ? owner_q : last_q;
    vga_plot_d = accept && in_bounds;
    vga_x_d = vga_plot_d ? cur_x : vga_x_q;
    vga_y_d = vga_plot_d ? cur_y : vga_y_q;
    vga_c_d = vga_plot_d ? cur_c : vga_c_q;
    drop_d = accept && !in_bounds && !(&drop_q) ? drop_q + CNT_W'(1) : drop_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q <= IW'(NUM_REQ - 1);
      vga_plot_q <= 1'b0;
      vga_x_q <= '0;
      vga_y_q <= '0;
      vga_c_q <= '0;
      drop_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q <= last_d;
      vga_plot_q <= vga_plot_d;
      vga_x_q <= vga_x_d;
      vga_y_q <= vga_y_d;
      vga_c_q <= vga_c_d;
      drop_q <= drop_d;
    end
  assign vga_x = vga_x_q;
  assign vga_y = vga_y_q;
  assign vga_colour = vga_c_q;
  assign vga_plot = vga_plot_q;
  assign drop_count = drop_q;
  assign busy = |gnt;
endmodule

// File: tb/tb_plot_arbiter.sv
// tb_plot_arbiter: directed and random stimulus against a cycle-level reference model of plot_arbiter
module tb_plot_arbiter;
  localparam int N = 3;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] req = '0, pix_valid = '0;
  logic [N*8-1:0] pix_x = '0;
  logic [N*7-1:0] pix_y = '0;
  logic [N*3-1:0] pix_colour = '0;
  logic [N-1:0] gnt, pix_ready;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic vga_plot, busy;
  logic [15:0] drop_count;
  plot_arbiter #(.NUM_REQ(N), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .gnt        (gnt),
    .pix_valid  (pix_valid),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_colour (pix_colour),
    .pix_ready  (pix_ready),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .busy       (busy),
    .drop_count (drop_count)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  int m_owner, m_last, m_x, m_y, m_c, m_drop, plots, idle_run;
  bit m_plot;
  int order[$], gaps[$];
  logic [N-1:0] prev_gnt;
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_owner = -1;
    m_last = N - 1;
    m_plot = 0;
    m_x = 0;
    m_y = 0;
    m_c = 0;
    m_drop = 0;
    prev_gnt = '0;
    idle_run = 0;
  endtask
  task automatic set_pix(int i, int x, int y, int c);
    pix_x[i*8 +: 8] = 8'(x);
    pix_y[i*7 +: 7] = 7'(y);
    pix_colour[i*3 +: 3] = 3'(c);
  endtask
  task automatic tick();
    logic [N-1:0] er;
    int px, py, gi;
    bit acc;
    #1;
    er = '0;
    if (m_owner >= 0 && req[m_owner]) er[m_owner] = 1'b1;
    check("pix_ready", 32'(pix_ready), 32'(er));
    acc = 0;
    if (er != 0) acc = pix_valid[m_owner];
    m_plot = 0;
    if (acc) begin
      px = int'(pix_x[m_owner*8 +: 8]);
      py = int'(pix_y[m_owner*7 +: 7]);
      if (px <= 159 && py <= 119) begin
        m_plot = 1;
        m_x = px;
        m_y = py;
        m_c = int'(pix_colour[m_owner*3 +: 3]);
      end else if (m_drop < 65535) m_drop++;
    end
    if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (m_last + k) % N;
        if (req[j]) begin
          m_owner = j;
          break;
        end
      end
    end else if (!req[m_owner]) begin
      m_last = m_owner;
      m_owner = -1;
    end
    @(posedge clk);
    #1;
    check("gnt", 32'(gnt), m_owner < 0 ? 32'd0 : 32'(1 << m_owner));
    check("busy", 32'(busy), 32'(m_owner >= 0));
    check("vga_plot", 32'(vga_plot), 32'(m_plot));
    check("vga_x", 32'(vga_x), 32'(m_x));
    check("vga_y", 32'(vga_y), 32'(m_y));
    check("vga_colour", 32'(vga_colour), 32'(m_c));
    check("drop_count", 32'(drop_count), 32'(m_drop));
    if (vga_plot) plots++;
    gi = -1;
    for (int i = 0; i < N; i++) if (gnt[i]) gi = i;
    if (gnt != 0) begin
      if (prev_gnt == 0) begin
        order.push_back(gi);
        gaps.push_back(idle_run);
      end
      idle_run = 0;
    end else idle_run++;
    prev_gnt = gnt;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_gnt_now", 32'(gnt), 32'd0);
    check("rst_plot_now", 32'(vga_plot), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_plot", 32'(vga_plot), 32'd0);
    check("rst_x", 32'(vga_x), 32'd0);
    check("rst_y", 32'(vga_y), 32'd0);
    check("rst_colour", 32'(vga_colour), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);
    rst_n = 1'b1;
  endtask
  initial begin
    int p0, o;
    #2;
    do_reset();
    req = 3'b001;
    set_pix(0, 10, 20, 2);
    pix_valid = 3'b001;
    tick();
    check("first_gnt", 32'(gnt), 32'd1);
    check("first_noplot", 32'(vga_plot), 32'd0);
    tick();
    check("first_plot", 32'(vga_plot), 32'd1);
    check("first_x", 32'(vga_x), 32'd10);
    check("first_y", 32'(vga_y), 32'd20);
    check("first_c", 32'(vga_colour), 32'd2);
    pix_valid = 3'b000;
    tick();
    set_pix(0, 30, 30, 1);
    pix_valid = 3'b001;
    req = 3'b000;
    tick();
    check("req_fall_noplot", 32'(vga_plot), 32'd0);
    check("req_fall_x", 32'(vga_x), 32'd10);
    pix_valid = 3'b000;
    tick();
    do_reset();
    order.delete();
    gaps.delete();
    req = 3'b111;
    tick();
    for (int r = 0; r < 3; r++) begin
      repeat (2) tick();
      o = m_owner < 0 ? 0 : m_owner;
      req[o] = 1'b0;
      tick();
      req[o] = 1'b1;
      tick();
    end
    check("rr_count", 32'(order.size()), 32'd4);
    check("rr_0", 32'(order.size() > 0 ? order[0] : -1), 32'd0);
    check("rr_1", 32'(order.size() > 1 ? order[1] : -1), 32'd1);
    check("rr_2", 32'(order.size() > 2 ? order[2] : -1), 32'd2);
    check("rr_3", 32'(order.size() > 3 ? order[3] : -1), 32'd0);
    for (int k = 1; k < 4; k++) check("rr_gap", 32'(gaps.size() > k ? gaps[k] : -1), 32'd1);
    do_reset();
    req = 3'b010;
    pix_valid = 3'b000;
    tick();
    check("stream_gnt", 32'(gnt), 32'd2);
    plots = 0;
    pix_valid = 3'b010;
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++) begin
        set_pix(1, x, y, (x + y) % 8);
        tick();
      end
    pix_valid = 3'b000;
    tick();
    check("stream_plots", 32'(plots), 32'd19200);
    check("stream_last_x", 32'(vga_x), 32'd159);
    check("stream_last_y", 32'(vga_y), 32'd119);
    check("stream_drop", 32'(drop_count), 32'd0);
    p0 = plots;
    pix_valid = 3'b010;
    set_pix(1, 160, 0, 1);
    tick();
    set_pix(1, 0, 120, 1);
    tick();
    set_pix(1, 159, 119, 5);
    tick();
    pix_valid = 3'b000;
    tick();
    check("clip_plots", 32'(plots - p0), 32'd1);
    check("clip_drop", 32'(drop_count), 32'd2);
    check("clip_x", 32'(vga_x), 32'd159);
    check("clip_y", 32'(vga_y), 32'd119);
    check("clip_c", 32'(vga_colour), 32'd5);
    set_pix(1, 50, 60, 4);
    pix_valid = 3'b010;
    tick();
    tick();
    check("pre_rst_plot", 32'(vga_plot), 32'd1);
    p0 = plots;
    do_reset();
    req = 3'b111;
    tick();
    check("post_rst_gnt", 32'(gnt), 32'd1);
    check("post_rst_noplot", 32'(vga_plot), 32'd0);
    check("post_rst_plots", 32'(plots - p0), 32'd0);
    req = 3'b000;
    pix_valid = 3'b000;
    tick();
    do_reset();
    req = 3'b101;
    set_pix(0, 5, 5, 1);
    set_pix(2, 200, 0, 7);
    pix_valid = 3'b100;
    tick();
    p0 = plots;
    repeat (4) tick();
    check("nonowner_ready", 32'(pix_ready[2]), 32'd0);
    check("nonowner_plots", 32'(plots - p0), 32'd0);
    check("nonowner_drop", 32'(drop_count), 32'd0);
    do_reset();
    repeat (400) begin
      if ($urandom_range(0, 7) == 0) req = 3'($urandom_range(0, 7));
      pix_valid = 3'($urandom);
      for (int i = 0; i < N; i++)
        set_pix(i, int'($urandom_range(0, 200)), int'($urandom_range(0, 127)), int'($urandom_range(0, 7)));
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
